// File: rtl/systolic_job_arbiter.sv
// Two-client, job-granular arbiter for one shared systolic array.
// Streams one size*size job per grant, waits out the drain latency, then holds a read window.
module systolic_job_arbiter #(
    parameter int size         = 16,
    parameter int nbits        = 16,
    parameter int DRAIN_CYCLES = 3*size-2,
    localparam int SW          = (size > 1) ? $clog2(size) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cl_req,
    input  logic [1:0]        cl_release,
    input  logic [2*nbits-1:0] cl_x_msg,
    input  logic [1:0]        cl_x_val,
    output logic [1:0]        cl_x_rdy,
    input  logic [2*nbits-1:0] cl_w_msg,
    input  logic [1:0]        cl_w_val,
    output logic [1:0]        cl_w_rdy,
    input  logic [2*SW-1:0]   cl_rsel,
    input  logic [2*SW-1:0]   cl_csel,
    output logic [nbits-1:0]  cl_out,
    output logic [1:0]        cl_out_val,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [nbits-1:0]  arr_x_msg,
    output logic              arr_x_val,
    input  logic              arr_x_rdy,
    output logic [nbits-1:0]  arr_w_msg,
    output logic              arr_w_val,
    input  logic              arr_w_rdy,
    output logic [SW-1:0]     arr_rsel,
    output logic [SW-1:0]     arr_csel,
    input  logic [nbits-1:0]  arr_out
);
    localparam int JOB_WORDS = size*size;
    localparam int CW        = $clog2(JOB_WORDS+1);
    localparam int DW        = $clog2(DRAIN_CYCLES+1);
    localparam logic [CW-1:0] JOB_C   = CW'(JOB_WORDS);
    localparam logic [DW-1:0] DRAIN_C = DW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, READ} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d, w_cnt_q, w_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;

    logic own, pick, x_open, w_open;

    assign own    = grant_q[1];
    assign x_open = (x_cnt_q < JOB_C);
    assign w_open = (w_cnt_q < JOB_C);
    assign grant  = grant_q;
    assign busy   = (state_q != IDLE);
    assign cl_out = arr_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            ptr_q       <= 1'b0;
            x_cnt_q     <= '0;
            w_cnt_q     <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            x_cnt_q     <= x_cnt_d;
            w_cnt_q     <= w_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        x_cnt_d     = x_cnt_q;
        w_cnt_d     = w_cnt_q;
        drain_cnt_d = drain_cnt_q;
        pick        = ptr_q;
        cl_x_rdy    = 2'b00;
        cl_w_rdy    = 2'b00;
        arr_x_val   = 1'b0;
        arr_w_val   = 1'b0;
        arr_rsel    = '0;
        arr_csel    = '0;
        cl_out_val  = 2'b00;
        arr_x_msg   = own ? cl_x_msg[2*nbits-1:nbits] : cl_x_msg[nbits-1:0];
        arr_w_msg   = own ? cl_w_msg[2*nbits-1:nbits] : cl_w_msg[nbits-1:0];

        case (state_q)
            IDLE: begin
                // The pointer side wins ties; it flips to the other client on release.
                if (cl_req[ptr_q] || cl_req[!ptr_q]) begin
                    pick    = cl_req[ptr_q] ? ptr_q : !ptr_q;
                    grant_d = pick ? 2'b10 : 2'b01;
                    state_d = STREAM;
                    x_cnt_d = '0;
                    w_cnt_d = '0;
                end
            end
            STREAM: begin
                arr_x_val      = cl_x_val[own] & x_open;
                arr_w_val      = cl_w_val[own] & w_open;
                cl_x_rdy[own]  = arr_x_rdy & x_open;
                cl_w_rdy[own]  = arr_w_rdy & w_open;
                if (arr_x_val && arr_x_rdy) x_cnt_d = x_cnt_q + 1'b1;
                if (arr_w_val && arr_w_rdy) w_cnt_d = w_cnt_q + 1'b1;
                if (x_cnt_d == JOB_C && w_cnt_d == JOB_C) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_C;
                end
            end
            DRAIN: begin
                if (drain_cnt_q <= DW'(1)) state_d = READ;
                if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 1'b1;
            end
            READ: begin
                arr_rsel        = own ? cl_rsel[2*SW-1:SW] : cl_rsel[SW-1:0];
                arr_csel        = own ? cl_csel[2*SW-1:SW] : cl_csel[SW-1:0];
                cl_out_val[own] = 1'b1;
                if (cl_release[own]) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    ptr_d   = !own;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/systolic_job_arbiter.md
Name: systolic_job_arbiter

Overview:
- Shares one systolic-array instance (x/w deserializer streams plus result-select read port) between two requesting clients at whole-job granularity.
- Grants round-robin and muxes the granted client's x/w streams onto the array.
- Counts one job's words, waits out the array drain latency, then opens a result-read window until the owner releases.
- Sits between client stream sources and the array top level.

Parameters:
size, 16, array dimension; one job = size*size words per stream
nbits, 16, stream word / result width
DRAIN_CYCLES, 3*size-2, cycles from last accepted word until results are valid

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cl_req  in  2  per-client job request
cl_release  in  2  per-client release of the read window
cl_x_msg  in  2*nbits  client x words, client i at [i*nbits +: nbits]
cl_x_val  in  2  client x valid
cl_x_rdy  out  2  client x ready
cl_w_msg  in  2*nbits  client w words, same packing as cl_x_msg
cl_w_val  in  2  client w valid
cl_w_rdy  out  2  client w ready
cl_rsel  in  2*$clog2(size)  client result row select
cl_csel  in  2*$clog2(size)  client result column select
cl_out  out  nbits  result word, broadcast to both clients
cl_out_val  out  2  result valid to owner (READ only)
grant  out  2  one-hot owner, 0 when idle
busy  out  1  state != IDLE
arr_x_msg  out  nbits  to array x stream
arr_x_val  out  1  array x valid
arr_x_rdy  in  1  array x ready
arr_w_msg  out  nbits  to array w stream
arr_w_val  out  1  array w valid
arr_w_rdy  in  1  array w ready
arr_rsel  out  $clog2(size)  to array out_rsel
arr_csel  out  $clog2(size)  to array out_csel
arr_out  in  nbits  from array b_s_out

Behaviour:
- States: IDLE, STREAM, DRAIN, READ. Constant JOB_WORDS = size*size.
- Registered: state, grant, round-robin pointer ptr, x_cnt, w_cnt, drain_cnt. Counter width $clog2(JOB_WORDS+1); drain_cnt width $clog2(DRAIN_CYCLES+1).
- Reset (any state, mid-job included): state=IDLE, grant=0, ptr=0, all counters 0. Outputs then: busy=0, cl_x_rdy=cl_w_rdy=0, arr_x_val=arr_w_val=0, cl_out_val=0, arr_rsel=arr_csel=0.
- IDLE arbitration:
  - If cl_req[ptr]=1, grant client ptr; else if cl_req[~ptr]=1, grant ~ptr.
  - Next cycle: grant one-hot, state=STREAM, counters cleared.
  - Simultaneous requests resolve to ptr.
  - Arbitration latency is exactly 1 cycle from request to grant.
- STREAM (combinational mux on grant; owner o):
  - arr_x_msg = cl_x_msg[o].
  - arr_x_val = cl_x_val[o] & (x_cnt < JOB_WORDS).
  - cl_x_rdy[o] = arr_x_rdy & (x_cnt < JOB_WORDS).
  - The w stream is muxed and gated identically using w_cnt.
  - Non-owner rdy = 0 always.
  - x_cnt increments on arr_x_val & arr_x_rdy; w_cnt increments likewise. Both saturate at JOB_WORDS, never wrap.
  - When both counters equal JOB_WORDS (including both finishing on the same cycle), next state = DRAIN with drain_cnt = DRAIN_CYCLES.
- DRAIN:
  - All stream val/rdy = 0.
  - drain_cnt decrements each cycle; when it reaches 1, next state = READ.
  - Total DRAIN dwell = DRAIN_CYCLES cycles.
- READ:
  - arr_rsel/arr_csel = owner's cl_rsel/cl_csel. cl_out = arr_out (combinational, 0 latency).
  - cl_out_val[o] = 1; non-owner bit = 0.
  - cl_release[o]=1 sets next state = IDLE, grant = 0, ptr = ~o.
- Outside READ: arr_rsel = arr_csel = 0; cl_out = arr_out regardless of state.
- Ignored inputs:
  - cl_req changes during STREAM/DRAIN/READ; the job always completes.
  - cl_release outside READ, and any non-owner release.
  - Non-owner val.
- The job counts array-side handshakes only. Client backpressure (val low) just stalls the counters; there is no timeout.

Test Plan (size=4, JOB_WORDS=16, DRAIN_CYCLES=10):
- Reset then only cl_req[0]=1 -> grant=01 next cycle; 16 x and 16 w words accepted with arr_*_rdy=1; DRAIN for 10 cycles; cl_out_val=01; cl_rsel[0]=2, cl_csel[0]=3 -> arr_rsel=2, arr_csel=3, cl_out mirrors arr_out.
- cl_req=11 from reset -> client 0 granted. After release[0], client 1 granted on the next IDLE cycle. After release[1] with cl_req=11 -> client 0 granted again (strict alternation).
- During client 0 STREAM, client 1 drives cl_x_val[1]=1 -> cl_x_rdy[1]=0 throughout, array sees only client 0 data. x completes at 16 while w sits at 9 -> x rdy drops, state stays STREAM until w reaches 16.
- arr_x_rdy toggles 1/0 each cycle -> x_cnt advances only on handshake cycles; the 17th offered x word is never accepted.
- cl_release[0]=1 during STREAM and DRAIN -> ignored, READ still reached. rst asserted at x_cnt=7 -> next cycle IDLE, grant=0, all outputs at reset values, ptr=0.
- Both counters reach 16 on the same cycle -> DRAIN entered the next cycle, READ exactly 10 cycles later.
